stopwatch_multi_ctrl: RTL and testbench

STOPWATCH_MULTI_CTRL -- requirements
Module: stopwatch_multi_ctrl

---
 rtl/stopwatch_multi_ctrl.sv | 111 +++++++++++
 tb/tb_stopwatch_multi_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_multi_ctrl.sv
// Multi-channel stopwatch: a shared prescaler strobe drives NUM_CH independent
// start/stop/clear controlled counters with wrap or saturate terminal handling.
module stopwatch_multi_ctrl #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 16,
  parameter int TICK_DIV  = 10,
  parameter int MAX_COUNT = 2**CNT_W-1,
  parameter int SAT_MODE  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       clear,
  output logic                    tick,
  output logic [NUM_CH-1:0]       count_enable,
  output logic [2*NUM_CH-1:0]     status,
  output logic [CNT_W*NUM_CH-1:0] count,
  output logic [NUM_CH-1:0]       done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_COUNT);
  localparam logic [CNT_W-1:0] MAX_C_M1   = CNT_W'(MAX_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    DONE    = 2'b11
  } state_t;

  logic [PW-1:0] presc_reg, presc_next;

  always_comb begin
    presc_next = (presc_reg == PRESC_LAST) ? '0 : presc_reg + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) presc_reg <= '0;
    else     presc_reg <= presc_next;
  end

  // With TICK_DIV=1 the prescaler sits at 0 == PRESC_LAST, so tick is constant high.
  assign tick = (presc_reg == PRESC_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t           state_reg, state_next;
      logic [CNT_W-1:0] count_reg, count_next;
      logic             done_reg, done_next;

      always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        done_next  = 1'b0;
        if (clear[gi]) begin
          state_next = IDLE;
          count_next = '0;
        end else begin
          case (state_reg)
            IDLE:    if (start[gi]) state_next = RUNNING;
            RUNNING: if (stop[gi])  state_next = PAUSED;
            PAUSED:  if (start[gi]) state_next = RUNNING;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
          endcase
          // A stop in the same cycle still lets the pending increment land.
          if (state_reg == RUNNING && tick) begin
            if (SAT_MODE == 0) begin
              if (count_reg == MAX_C) begin
                count_next = '0;
                done_next  = 1'b1;
              end else begin
                count_next = count_reg + CNT_W'(1);
              end
            end else begin
              if (count_reg == MAX_C_M1) begin
                count_next = MAX_C;
                state_next = DONE;
                done_next  = 1'b1;
              end else begin
                count_next = count_reg + CNT_W'(1);
              end
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= IDLE;
          count_reg <= '0;
          done_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          count_reg <= count_next;
          done_reg  <= done_next;
        end
      end

      assign count_enable[gi]           = (state_reg == RUNNING);
      assign status[2*gi +: 2]          = state_reg;
      assign count[CNT_W*gi +: CNT_W]   = count_reg;
      assign done[gi]                   = done_reg;
    end
  endgenerate

endmodule

// File: tb/tb_stopwatch_multi_ctrl.sv
// Bench for stopwatch_multi_ctrl: a wrap-mode and a saturate-mode instance share
// one stimulus stream and are compared every cycle against a behavioural model.
module tb_stopwatch_multi_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start, stop, clear;

  logic       tick_a, tick_b;
  logic [1:0] en_a, en_b, done_a, done_b;
  logic [3:0] status_a, status_b;
  logic [7:0] count_a, count_b;

  int errs   = 0;
  int checks = 0;
  bit armed  = 0;

  // model state: [instance][channel]; instance 0 = wrap, 1 = saturate
  int m_st[2][2];
  int m_cnt[2][2];
  int m_done[2][2];
  int m_pc = 0;

  always #5 clk = ~clk;

  stopwatch_multi_ctrl #(.NUM_CH(2), .CNT_W(4), .TICK_DIV(3), .MAX_COUNT(5), .SAT_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .tick(tick_a), .count_enable(en_a), .status(status_a), .count(count_a), .done(done_a)
  );

  stopwatch_multi_ctrl #(.NUM_CH(2), .CNT_W(4), .TICK_DIV(3), .MAX_COUNT(5), .SAT_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .tick(tick_b), .count_enable(en_b), .status(status_b), .count(count_b), .done(done_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural model: states 0 idle, 1 running, 2 paused, 3 done; tick every 3rd cycle.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_pc  = 0;
      armed = 1;
      for (int m = 0; m < 2; m++)
        for (int c = 0; c < 2; c++) begin
          m_st[m][c] = 0; m_cnt[m][c] = 0; m_done[m][c] = 0;
        end
    end else begin
      bit tk;
      tk   = (m_pc == 2);
      m_pc = (m_pc + 1) % 3;
      for (int m = 0; m < 2; m++)
        for (int c = 0; c < 2; c++) begin
          int st, cn, dn;
          st = m_st[m][c]; cn = m_cnt[m][c]; dn = 0;
          if (clear[c]) begin
            st = 0; cn = 0;
          end else begin
            bit running;
            running = (m_st[m][c] == 1);
            if (st == 0 && start[c]) st = 1;
            else if (st == 1 && stop[c]) st = 2;
            else if (st == 2 && start[c]) st = 1;
            if (running && tk) begin
              cn = cn + 1;
              if (m == 0 && cn > 5) begin cn = 0; dn = 1; end
              else if (m == 1 && cn == 5) begin st = 3; dn = 1; end
            end
          end
          m_st[m][c] = st; m_cnt[m][c] = cn; m_done[m][c] = dn;
        end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge clk);
    if (armed) begin
      for (int m = 0; m < 2; m++) begin
        logic [1:0] e_en, e_done;
        logic [3:0] e_st;
        logic [7:0] e_cnt;
        logic       e_tick;
        e_tick = (m_pc == 2);
        for (int c = 0; c < 2; c++) begin
          e_en[c]          = (m_st[m][c] == 1);
          e_done[c]        = (m_done[m][c] != 0);
          e_st[2*c +: 2]   = 2'(m_st[m][c]);
          e_cnt[4*c +: 4]  = 4'(m_cnt[m][c]);
        end
        check($sformatf("model_tick_%0d", m),   32'(m ? tick_b   : tick_a),   32'(e_tick));
        check($sformatf("model_en_%0d", m),     32'(m ? en_b     : en_a),     32'(e_en));
        check($sformatf("model_status_%0d", m), 32'(m ? status_b : status_a), 32'(e_st));
        check($sformatf("model_count_%0d", m),  32'(m ? count_b  : count_a),  32'(e_cnt));
        check($sformatf("model_done_%0d", m),   32'(m ? done_b   : done_a),   32'(e_done));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] c0;
    rst = 1'b1; start = '0; stop = '0; clear = '0;
    step(3);
    check("rst_status", 32'(status_a), 0);
    check("rst_count", 32'(count_a), 0);
    check("rst_tick", 32'(tick_a), 0);
    check("rst_done", 32'(done_b), 0);
    rst = 1'b0;

    // start channel 0, channel 1 stays idle
    start = 2'b01; step(1); start = '0;
    check("start_status", 32'(status_a), 32'h1);
    c0 = count_a[3:0];
    step(3);
    check("advance_one", 32'(count_a[3:0]), 32'(4'(c0 + 4'd1)));
    check("ch1_idle_status", 32'(status_a[3:2]), 0);
    check("ch1_idle_count", 32'(count_a[7:4]), 0);

    // pause at 3 just after an increment, then resume
    for (int k = 0; k < 12 && count_a[3:0] != 4'd3; k++) step(1);
    check("reach3", 32'(count_a[3:0]), 3);
    stop = 2'b01; step(1); stop = '0;
    check("paused_status", 32'(status_a[1:0]), 2);
    step(5);
    check("paused_hold", 32'(count_a[3:0]), 3);
    start = 2'b01; step(1); start = '0;
    check("resume_status", 32'(status_a[1:0]), 1);
    check("resume_count", 32'(count_a[3:0]), 3);
    for (int k = 0; k < 4 && count_a[3:0] != 4'd4; k++) step(1);
    check("resume_inc", 32'(count_a[3:0]), 4);

    // wrap on instance a, saturation on instance b
    for (int k = 0; k < 20 && done_a[0] != 1'b1; k++) step(1);
    check("wrap_done", 32'(done_a[0]), 1);
    check("wrap_count", 32'(count_a[3:0]), 0);
    check("wrap_status", 32'(status_a[1:0]), 1);
    check("sat_status", 32'(status_b[1:0]), 3);
    check("sat_count", 32'(count_b[3:0]), 5);
    step(1);
    check("wrap_done_1cyc", 32'(done_a[0]), 0);

    start = 2'b01; stop = 2'b01; step(1); start = '0; stop = '0;
    check("sat_ignore", 32'(status_b[1:0]), 3);
    check("both_run_pause", 32'(status_a[1:0]), 2);
    clear = 2'b01; step(1); clear = '0;
    check("sat_clear_status", 32'(status_b[1:0]), 0);
    check("sat_clear_count", 32'(count_b[3:0]), 0);

    // channel 1: simultaneous start/stop, then clear with start
    start = 2'b10; stop = 2'b10; step(1); start = '0; stop = '0;
    check("ss_idle_run", 32'(status_a[3:2]), 1);
    step(7);
    check("ch1_counted", 32'(count_a[7:4] != 4'd0), 1);
    start = 2'b10; stop = 2'b10; step(1); start = '0; stop = '0;
    check("ss_run_pause", 32'(status_a[3:2]), 2);
    clear = 2'b10; start = 2'b10; step(1); clear = '0; start = '0;
    check("clr_start_status", 32'(status_a[3:2]), 0);
    check("clr_start_count", 32'(count_a[7:4]), 0);

    // reset mid-count with counts 4 and 2
    clear = 2'b11; step(1); clear = '0;
    start = 2'b01; step(1); start = '0;
    for (int k = 0; k < 12 && count_a[3:0] != 4'd2; k++) step(1);
    start = 2'b10; step(1); start = '0;
    for (int k = 0; k < 12 && count_a[3:0] != 4'd4; k++) step(1);
    check("pre_rst_ch0", 32'(count_a[3:0]), 4);
    check("pre_rst_ch1", 32'(count_a[7:4]), 2);
    rst = 1'b1; step(1);
    check("mid_rst_status", 32'({status_a, status_b}), 0);
    check("mid_rst_count", 32'({count_a, count_b}), 0);
    check("mid_rst_done", 32'({done_a, done_b}), 0);
    check("mid_rst_tick", 32'(tick_a), 0);
    rst = 1'b0;
    step(1);
    check("presc_restart0", 32'(tick_a), 0);
    step(1);
    check("presc_restart1", 32'(tick_a), 1);
    step(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
